// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, a 2-entry skid buffer and synchronous flush.
// Optional stall-cycle counter port stall_cnt_o is enabled by defining PIPE_STAGE_STALL_CNT_EN.
`timescale 1ns/1ps
module pipe_stage_reg #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          PC_W     = 32,
  parameter logic [DATA_W-1:0]    NOP_DATA = {DATA_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [PC_W-1:0]   out_pc_o
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire_s;
  logic              out_fire_s;

  assign in_fire_s  = in_valid_i & in_ready_q;
  assign out_fire_s = out_valid_q & out_ready_i;

  // Next-state and datapath selection; flush overrides every handshake event.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_pc_d   = main_pc_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire_s) begin
          state_d     = ST_FULL;
          main_data_d = in_data_i;
          main_pc_d   = in_pc_i;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (in_fire_s && out_fire_s) begin
          main_data_d = in_data_i;
          main_pc_d   = in_pc_i;
        end else if (in_fire_s) begin
          // Downstream stalled: park the new word so ready can stay registered.
          state_d     = ST_SKID;
          skid_data_d = in_data_i;
          skid_pc_d   = in_pc_i;
        end else if (out_fire_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      ST_SKID: begin
        if (out_fire_s) begin
          state_d     = ST_FULL;
          main_data_d = skid_data_q;
          main_pc_d   = skid_pc_q;
        end else begin
          state_d = ST_SKID;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (flush_i) begin
      state_d     = ST_EMPTY;
      main_data_d = NOP_DATA;
      main_pc_d   = {PC_W{1'b0}};
      skid_data_d = {DATA_W{1'b0}};
      skid_pc_d   = {PC_W{1'b0}};
    end else begin
      state_d = state_d;
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_SKID);
  end

  // State and payload registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= NOP_DATA;
      main_pc_q   <= {PC_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      skid_pc_q   <= {PC_W{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_pc_q   <= main_pc_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_data_q;
  assign out_pc_o    = main_pc_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where a valid word is held back; flush does not clear it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver pushes expected words, a negedge monitor pops on out_fire.
`timescale 1ns/1ps
module tb_pipe_stage_reg;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_data_i = 32'h0;
  logic [31:0] in_pc_i = 32'h0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_data_o;
  logic [31:0] out_pc_o;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  pipe_stage_reg dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_pc_i     (in_pc_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_pc_o    (out_pc_o)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [31:0] d, input logic [31:0] pc);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_pc_i    = pc;
    exp_q.push_back({d, pc});
  endtask

  // Monitor: every out_fire must match the oldest expected word.
  always @(negedge clk_i) begin
    if (rst_n && !flush_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h/%h expected none", out_data_o, out_pc_o);
      end else begin
        chk("out_word", {out_data_o, out_pc_o}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset then idle
    cyc(); cyc();
    rst_n = 1'b1;
    @(negedge clk_i);
    chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
    chk("rst_out_data", {32'd0, out_data_o}, 64'd0);
    chk("rst_out_pc", {32'd0, out_pc_o}, 64'd0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("rst_stall_cnt", {48'd0, stall_cnt_o}, 64'd0);
`endif
    cyc();

    // Streaming at full rate
    out_ready_i = 1'b1;
    issue(32'h11, 32'h0);
    cyc();
    chk("lat_out_valid", {63'd0, out_valid_o}, 64'd1);
    chk("lat_out_data", {32'd0, out_data_o}, 64'h11);
    issue(32'h22, 32'h4);
    cyc();
    chk("stream_in_ready", {63'd0, in_ready_o}, 64'd1);
    chk("stream_out_data2", {32'd0, out_data_o}, 64'h22);
    issue(32'h33, 32'h8);
    cyc();
    chk("stream_out_data3", {32'd0, out_data_o}, 64'h33);
    in_valid_i = 1'b0;
    cyc();
    chk("stream_drained", {63'd0, out_valid_o}, 64'd0);

    // Back-pressure into the skid buffer
    out_ready_i = 1'b0;
    issue(32'hA0, 32'h10);
    cyc();
    chk("bp_ready_full", {63'd0, in_ready_o}, 64'd1);
    issue(32'hB0, 32'h14);
    cyc();
    in_valid_i = 1'b0;
    chk("bp_ready_skid", {63'd0, in_ready_o}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold_data", {32'd0, out_data_o}, 64'hA0);
      chk("bp_hold_pc", {32'd0, out_pc_o}, 64'h10);
    end
    out_ready_i = 1'b1;
    cyc();
    chk("bp_ready_back", {63'd0, in_ready_o}, 64'd1);
    chk("bp_second_data", {32'd0, out_data_o}, 64'hB0);
    cyc();
    chk("bp_empty", {63'd0, out_valid_o}, 64'd0);

    // Flush while in SKID with a new word offered
    out_ready_i = 1'b0;
    issue(32'hA0, 32'h10);
    cyc();
    issue(32'hB0, 32'h14);
    cyc();
    in_data_i = 32'hC0;
    in_pc_i   = 32'h18;
    flush_i   = 1'b1;
    exp_q.delete();
    cyc();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("flush_out_data", {32'd0, out_data_o}, 64'd0);
    chk("flush_out_pc", {32'd0, out_pc_o}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready_o}, 64'd1);
    out_ready_i = 1'b1;
    cyc(); cyc();
    chk("flush_no_c0", {63'd0, out_valid_o}, 64'd0);

    // Flush in FULL discards a word fired on the same edge
    out_ready_i = 1'b0;
    issue(32'h55, 32'h20);
    cyc();
    in_data_i = 32'h66;
    flush_i   = 1'b1;
    exp_q.delete();
    cyc();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    cyc();
    chk("flush_fire_dropped", {63'd0, out_valid_o}, 64'd0);

    // Reset mid-stream while FULL and stalled
    issue(32'hD0, 32'h30);
    cyc();
    in_valid_i = 1'b0;
    chk("mid_full", {63'd0, out_valid_o}, 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    cyc();
    chk("mid_rst_valid", {63'd0, out_valid_o}, 64'd0);
    chk("mid_rst_ready", {63'd0, in_ready_o}, 64'd1);
    chk("mid_rst_data", {32'd0, out_data_o}, 64'd0);
    chk("mid_rst_pc", {32'd0, out_pc_o}, 64'd0);
    rst_n = 1'b1;
    cyc();

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Saturating stall counter, untouched by flush
    issue(32'hE0, 32'h40);
    cyc();
    in_valid_i = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      cyc();
    end
    chk("stall_sat", {48'd0, stall_cnt_o}, 64'hFFFF);
    flush_i = 1'b1;
    exp_q.delete();
    cyc();
    flush_i = 1'b0;
    cyc();
    chk("stall_after_flush", {48'd0, stall_cnt_o}, 64'hFFFF);
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
